// File: rtl/as_pack.sv
// Shared core package: widths, ALU select codes and the ALU-arbiter types.
package as_pack;

  localparam int reg_width      = 64;
  localparam int aluselrv_width = 4;
  localparam int ALUARB_REQ_N   = 2;

  localparam logic [aluselrv_width-1:0] ALU_ADD  = 4'd0;
  localparam logic [aluselrv_width-1:0] ALU_SUB  = 4'd1;
  localparam logic [aluselrv_width-1:0] ALU_AND  = 4'd2;
  localparam logic [aluselrv_width-1:0] ALU_OR   = 4'd3;
  localparam logic [aluselrv_width-1:0] ALU_XOR  = 4'd4;
  localparam logic [aluselrv_width-1:0] ALU_SLL  = 4'd5;
  localparam logic [aluselrv_width-1:0] ALU_SRL  = 4'd6;
  localparam logic [aluselrv_width-1:0] ALU_SRA  = 4'd7;
  localparam logic [aluselrv_width-1:0] ALU_SLT  = 4'd8;
  localparam logic [aluselrv_width-1:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} aluarb_state_t;

  typedef struct packed {
    logic over;
    logic carr;
    logic nega;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/as_alurv.sv
// RV64I integer ALU with Z/N/C/O flags; SUB carry uses the no-borrow convention.
module as_alurv
  import as_pack::*;
#(
  parameter int WIDTH = reg_width,
  parameter int SEL_W = aluselrv_width
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;

  assign sh = b[SHW-1:0];

  always_comb begin
    sum        = '0;
    result     = '0;
    flags.carr = 1'b0;
    flags.over = 1'b0;
    case (sel)
      ALU_ADD: begin
        sum        = {1'b0, a} + {1'b0, b};
        result     = sum[WIDTH-1:0];
        flags.carr = sum[WIDTH];
        flags.over = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sum        = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result     = sum[WIDTH-1:0];
        flags.carr = sum[WIDTH];
        flags.over = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << sh;
      ALU_SRL:  result = a >> sh;
      ALU_SRA:  result = $signed(a) >>> sh;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
    flags.zero = (result == '0);
    flags.nega = result[WIDTH-1];
  end

endmodule

// File: rtl/as_rr_arb2.sv
// Two-way one-hot grant: fixed priority to requester 0, or on a tie the
// requester that was NOT granted last when round-robin is enabled.
module as_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       rrEn,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (rrEn && (req == 2'b11)) gnt = ptr ? 2'b01 : 2'b10;
    else if (req[0])            gnt = 2'b01;
    else if (req[1])            gnt = 2'b10;
  end

endmodule

// File: rtl/as_alu_arbiter.sv
// Shares one as_alurv between two requesters, one operation in flight.
// Define AS_ALUARB_RR_EN for round-robin arbitration (default: fixed priority).
module as_alu_arbiter
  import as_pack::*;
#(
  parameter int WIDTH = reg_width,
  parameter int SEL_W = aluselrv_width
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [ALUARB_REQ_N-1:0]             req_valid_i,
  output logic [ALUARB_REQ_N-1:0]             req_ready_o,
  input  logic [ALUARB_REQ_N-1:0][WIDTH-1:0]  req_a_i,
  input  logic [ALUARB_REQ_N-1:0][WIDTH-1:0]  req_b_i,
  input  logic [ALUARB_REQ_N-1:0][SEL_W-1:0]  req_sel_i,
  output logic [ALUARB_REQ_N-1:0]             rsp_valid_o,
  input  logic [ALUARB_REQ_N-1:0]             rsp_ready_i,
  output logic [WIDTH-1:0]                    rsp_result_o,
  output logic [3:0]                          rsp_flags_o,
  output logic                                busy_o
);

  aluarb_state_t    state, nxt;
  logic [WIDTH-1:0] aReg, bReg, resReg, aluRes;
  logic [SEL_W-1:0] selReg;
  logic             gReg, lastGnt, rrEn, accept;
  logic [1:0]       gnt;
  alu_flags_t       flagsReg, aluFlags;

  assign accept = (state == IDLE) && (|req_valid_i);

`ifdef AS_ALUARB_RR_EN
  assign rrEn = 1'b1;
  // Reset to "1 granted last" so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       lastGnt <= 1'b1;
    else if (accept) lastGnt <= gnt[1];
  end
`else
  assign rrEn    = 1'b0;
  assign lastGnt = 1'b1;
`endif

  as_rr_arb2 uArb (.req(req_valid_i), .ptr(lastGnt), .rrEn(rrEn), .gnt(gnt));

  as_alurv #(.WIDTH(WIDTH), .SEL_W(SEL_W)) uAlu (
    .a(aReg), .b(bReg), .sel(selReg), .result(aluRes), .flags(aluFlags)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      aReg     <= '0;
      bReg     <= '0;
      selReg   <= '0;
      gReg     <= 1'b0;
      resReg   <= '0;
      flagsReg <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        aReg   <= req_a_i[gnt[1]];
        bReg   <= req_b_i[gnt[1]];
        selReg <= req_sel_i[gnt[1]];
        gReg   <= gnt[1];
      end
      if (state == EXEC) begin
        resReg   <= aluRes;
        flagsReg <= aluFlags;
      end
    end
  end

  always_comb begin
    nxt         = state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (state)
      IDLE: if (|req_valid_i) begin
        req_ready_o = gnt;
        nxt         = EXEC;
      end
      EXEC: nxt = RESP;
      RESP: begin
        rsp_valid_o[gReg] = 1'b1;
        if (rsp_ready_i[gReg]) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign rsp_result_o = resReg;
  assign rsp_flags_o  = flagsReg;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_as_alu_arbiter.sv
// Directed self-checking bench for as_alu_arbiter (honours AS_ALUARB_RR_EN).
module tb_as_alu_arbiter;
  import as_pack::*;

  localparam int W = reg_width;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            reqValid, reqReady, rspValid, rspReady;
  logic [1:0][W-1:0]     reqA, reqB;
  logic [1:0][3:0]       reqSel;
  logic [W-1:0]          rspResult;
  logic [3:0]            rspFlags;
  logic                  busy;

  int nChk = 0;
  int nPass = 0;

  always #5 clk = ~clk;

  as_alu_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady),
    .req_a_i(reqA), .req_b_i(reqB), .req_sel_i(reqSel),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
    .rsp_result_o(rspResult), .rsp_flags_o(rspFlags), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Starts just after a posedge with the DUT idle; ends just after the
  // edge that returns it to IDLE.
  task automatic runOp(input string tag, input int r, input logic [63:0] a, b,
                       input logic [3:0] sel, input logic [63:0] er, input logic [3:0] ef);
    reqValid = 2'b00; reqValid[r] = 1'b1;
    reqA[r] = a; reqB[r] = b; reqSel[r] = sel; rspReady = 2'b11;
    @(negedge clk); chk({tag, ".rdy"}, reqReady, 64'(1 << r));
    @(posedge clk); #1 reqValid = 2'b00;
    @(negedge clk); chk({tag, ".exec"}, {busy, reqReady, rspValid}, {1'b1, 2'b00, 2'b00});
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".vld"}, rspValid, 64'(1 << r));
    chk({tag, ".res"}, rspResult, er);
    chk({tag, ".flg"}, rspFlags, ef);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; reqValid = '0; reqA = '0; reqB = '0; reqSel = '0; rspReady = '0;
    @(negedge clk);
    chk("rst.out", {busy, reqReady, rspValid, rspFlags}, '0);
    chk("rst.res", rspResult, '0);
    @(posedge clk); #1 rst = 1'b0;

    runOp("add0", 0, 64'hF, 64'hA, ALU_ADD, 64'h19, 4'b0000);
    runOp("sub1", 1, 64'd2, 64'd4, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010);
    runOp("ovf0", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'h8000_0000_0000_0000, 4'b1010);

    // Backpressure: requester 1 SUB 5-3, only the non-granted ready is high.
    reqValid = 2'b10; reqA[1] = 64'd5; reqB[1] = 64'd3; reqSel[1] = ALU_SUB; rspReady = 2'b01;
    @(negedge clk); chk("bp.rdy", reqReady, 64'b10);
    @(posedge clk); #1 reqValid = 2'b00;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold", {busy, reqReady, rspValid, rspFlags}, {1'b1, 2'b00, 2'b10, 4'b0100});
      chk("bp.res", rspResult, 64'd2);
      @(posedge clk);
    end
    #1 rspReady = 2'b10;
    @(negedge clk); chk("bp.last", rspValid, 64'b10);
    @(posedge clk);
    @(negedge clk); chk("bp.done", {busy, rspValid}, {1'b0, 2'b00});

    // Reset pulse while in EXEC (result register currently holds 2).
    reqValid = 2'b01; reqA[0] = 64'd1; reqB[0] = 64'd1; reqSel[0] = ALU_ADD; rspReady = 2'b11;
    @(posedge clk); #1 reqValid = 2'b00;
    chk("mid.busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 chk("mid.out", {busy, reqReady, rspValid, rspFlags}, '0);
    chk("mid.res", rspResult, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("mid.idle", busy, 1'b0);
    @(posedge clk); #1;
    runOp("zero0", 0, 64'd0, 64'd0, ALU_ADD, 64'd0, 4'b0001);

    // Both requesters valid continuously, starting from reset state.
    rst = 1'b1; #2 rst = 1'b0;
    @(posedge clk); #1;
    reqA[0] = 64'd1; reqB[0] = 64'd1; reqSel[0] = ALU_ADD;
    reqA[1] = 64'd3; reqB[1] = 64'd4; reqSel[1] = ALU_ADD;
    reqValid = 2'b11; rspReady = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int g;
`ifdef AS_ALUARB_RR_EN
      g = i % 2;
`else
      g = 0;
`endif
      @(negedge clk); chk("arb.gnt", reqReady, 64'(1 << g));
      @(posedge clk);
      @(negedge clk); chk("arb.exec", reqReady, 64'b00);
      @(posedge clk);
      @(negedge clk);
      chk("arb.vld", rspValid, 64'(1 << g));
      chk("arb.res", rspResult, (g == 0) ? 64'd2 : 64'd7);
      @(posedge clk);
    end
    #1 reqValid = 2'b00;

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
